// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, one-word-per-line instruction cache sitting between the
//   datapath fetch port and the memory controller instruction port.
//   Hits return combinationally in the lookup cycle. Misses go through a
//   single-outstanding fill FSM (IDLE -> FILL -> IDLE). A flush clears every
//   valid bit so the cache can be cleaned on halt or after a self-modifying
//   store. The cache is read-only, so a conflicting fill simply overwrites.
//
// Optional feature macro: ICACHE_FILL_FORWARD_EN
//   When defined, the fill-completion cycle forwards iload straight to the
//   requester if it is still asking for the word being filled.
//
// Ports
//   CLK       in   1       clock, all state updates on posedge
//   RST       in   1       synchronous active-high reset
//   imemREN   in   1       datapath fetch request
//   imemaddr  in   ADDR_W  fetch byte address (bits [1:0] ignored)
//   flush     in   1       invalidate all lines
//   ihit      out  1       imemload valid this cycle
//   imemload  out  WORD_W  fetched instruction
//   iREN      out  1       memory read request
//   iaddr     out  ADDR_W  memory read address (word aligned)
//   iwait     in   1       memory busy; data valid when iREN=1 and iwait=0
//   iload     in   WORD_W  memory read data
// ---------------------------------------------------------------------------
module icache_direct #(
  parameter int SETS   = 16,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  state_e            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [WORD_W-1:0] data_q [SETS];
  logic [ADDR_W-1:0] fetchAddr_q;

  logic [IDX_W-1:0]  lookupIdx;
  logic [TAG_W-1:0]  lookupTag;
  logic [IDX_W-1:0]  fillIdx;
  logic [TAG_W-1:0]  fillTag;
  logic              lookupHit;
  logic              idleHit;
  logic              fwdHit;
  logic              fillDone;
  logic              unusedAddrBits;

  // The byte offset never selects anything in a one-word line.
  assign unusedAddrBits = ^imemaddr[1:0];

  assign lookupIdx = imemaddr[IDX_W+1:2];
  assign lookupTag = imemaddr[ADDR_W-1:IDX_W+2];
  assign fillIdx   = fetchAddr_q[IDX_W+1:2];
  assign fillTag   = fetchAddr_q[ADDR_W-1:IDX_W+2];

  assign lookupHit = imemREN & valid_q[lookupIdx] & (tag_q[lookupIdx] == lookupTag);
  assign fillDone  = (state_q == FILL) & ~iwait;

  // Hits are only reported in IDLE, and nothing is reported while reset is
  // held even though state_q has not yet returned to IDLE.
  assign idleHit = ~RST & (state_q == IDLE) & lookupHit;

`ifdef ICACHE_FILL_FORWARD_EN
  // Forward the returning word when the requester still wants the same word.
  assign fwdHit = ~RST & fillDone & imemREN &
                  (imemaddr[ADDR_W-1:2] == fetchAddr_q[ADDR_W-1:2]);
`else
  assign fwdHit = 1'b0;
`endif

  assign ihit  = idleHit | fwdHit;
  assign iREN  = ~RST & (state_q == FILL);
  assign iaddr = fetchAddr_q;

  // Read data mux; stays zero whenever nothing is being returned.
  always_comb begin
    imemload = '0;
    if (idleHit) begin
      imemload = data_q[lookupIdx];
    end else if (fwdHit) begin
      imemload = iload;
    end
  end

  // Fill FSM plus the valid array. A fill is never aborted once started, and
  // flush is applied after the fill write so that flush wins on a tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      fetchAddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !lookupHit) begin
            fetchAddr_q <= {imemaddr[ADDR_W-1:2], 2'b00};
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            valid_q[fillIdx] <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fillDone) begin
      tag_q[fillIdx]  <= fillTag;
      data_q[fillIdx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//   Directed bench for icache_direct. Stimulus pushes every expected ihit
//   (cycle number and word) into a queue; an independent monitor on the
//   falling edge pops and compares whenever a hit is due or presented.
//   Memory-side outputs (iREN/iaddr) are checked directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_icache_direct;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        flush = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  int          expCycle[$];
  logic [31:0] expData[$];

  icache_direct #(.SETS(16), .ADDR_W(32), .WORD_W(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  // Free-running clock and cycle counter used to time-stamp expectations.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount <= cycleCount + 1;

  // Monitor: compares presented hits against the queued expectations.
  always @(negedge CLK) begin
    while (expCycle.size() > 0 && expCycle[0] < cycleCount) begin
      checks++;
      errors++;
      $display("[TB] FAIL missedHit: expected hit in cycle %0d never checked (now %0d)",
               expCycle[0], cycleCount);
      void'(expCycle.pop_front());
      void'(expData.pop_front());
    end
    if (expCycle.size() > 0 && expCycle[0] == cycleCount) begin
      checks++;
      if (!ihit) begin
        errors++;
        $display("[TB] FAIL hitPresent cycle %0d: ihit=%0b required 1", cycleCount, ihit);
      end else if (imemload !== expData[0]) begin
        errors++;
        $display("[TB] FAIL hitData cycle %0d: imemload=%08h required %08h",
                 cycleCount, imemload, expData[0]);
      end
      void'(expCycle.pop_front());
      void'(expData.pop_front());
    end else if (ihit) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedHit cycle %0d: ihit=1 imemload=%08h required ihit=0",
               cycleCount, imemload);
    end
  end

  // Drive one cycle of inputs just after the rising edge, return at the
  // falling edge so the caller can sample outputs.
  task automatic applyStimulus(input logic r, input logic ren, input logic [31:0] a,
                               input logic f, input logic w, input logic [31:0] d);
    @(posedge CLK);
    #1;
    RST      = r;
    imemREN  = ren;
    imemaddr = a;
    flush    = f;
    iwait    = w;
    iload    = d;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %08h required %08h", name, cycleCount,
               actual, expected);
    end
  endtask

  // Called between cycles: the next applied cycle is cycleCount + 1.
  task automatic expectHitNext(input logic [31:0] d);
    expCycle.push_back(cycleCount + 1);
    expData.push_back(d);
  endtask

  // Miss in IDLE, 'waits' busy memory cycles, then completion with data.
  task automatic missFill(input logic [31:0] a, input logic [31:0] d, input int waits,
                          input logic flushAtEnd);
    applyStimulus(1'b0, 1'b1, a, 1'b0, 1'b1, JUNK);
    checkOutput("idleNoReq", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      applyStimulus(1'b0, 1'b1, a, 1'b0, 1'b1, JUNK);
      checkOutput("fillReq", {31'd0, iREN}, 32'd1);
      checkOutput("fillAddr", iaddr, a);
    end
`ifdef ICACHE_FILL_FORWARD_EN
    expectHitNext(d);
`endif
    applyStimulus(1'b0, 1'b1, a, flushAtEnd, 1'b0, d);
    checkOutput("fillDoneReq", {31'd0, iREN}, 32'd1);
    checkOutput("fillDoneAddr", iaddr, a);
  endtask

  task automatic hitCycle(input logic [31:0] a, input logic [31:0] d, input logic f);
    expectHitNext(d);
    applyStimulus(1'b0, 1'b1, a, f, 1'b1, JUNK);
    checkOutput("hitNoReq", {31'd0, iREN}, 32'd0);
  endtask

  initial begin
    $display("[TB] icache_direct directed test start");

    // Reset: nothing requested or reported while RST is held, clean after.
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, JUNK);
    checkOutput("rstNoReq", {31'd0, iREN}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, JUNK);
    checkOutput("rstNoReq2", {31'd0, iREN}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JUNK);
    checkOutput("postRstHit", {31'd0, ihit}, 32'd0);
    checkOutput("postRstReq", {31'd0, iREN}, 32'd0);
    checkOutput("postRstAddr", iaddr, 32'd0);
    checkOutput("postRstLoad", imemload, 32'd0);

    // Cold miss with two busy memory cycles, then the hit, then a re-fetch.
    missFill(32'h40, 32'h2001_0005, 2, 1'b0);
    hitCycle(32'h40, 32'h2001_0005, 1'b0);
    hitCycle(32'h40, 32'h2001_0005, 1'b0);

    // Idle with no request stays idle.
    applyStimulus(1'b0, 1'b0, 32'h40, 1'b0, 1'b1, JUNK);
    applyStimulus(1'b0, 1'b0, 32'h40, 1'b0, 1'b1, JUNK);
    checkOutput("idleStays", {31'd0, iREN}, 32'd0);

    // Conflict: 0x440 evicts 0x40, which then misses again.
    missFill(32'h440, 32'h8C22_0004, 1, 1'b0);
    hitCycle(32'h440, 32'h8C22_0004, 1'b0);
    missFill(32'h40, 32'h2001_0006, 0, 1'b0);
    hitCycle(32'h40, 32'h2001_0006, 1'b0);

    // Address changes mid-fill: fill for 0x80 completes, then 0xC0 misses.
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, JUNK);
    checkOutput("squashIdle", {31'd0, iREN}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hC0, 1'b0, 1'b1, JUNK);
    checkOutput("squashReq", {31'd0, iREN}, 32'd1);
    checkOutput("squashAddr", iaddr, 32'h80);
    applyStimulus(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0000_1111);
    checkOutput("squashDoneAddr", iaddr, 32'h80);
    applyStimulus(1'b0, 1'b1, 32'hC0, 1'b0, 1'b1, JUNK);
    checkOutput("squashMissIdle", {31'd0, iREN}, 32'd0);
`ifdef ICACHE_FILL_FORWARD_EN
    expectHitNext(32'h0000_22C0);
`endif
    applyStimulus(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0000_22C0);
    checkOutput("newFillReq", {31'd0, iREN}, 32'd1);
    checkOutput("newFillAddr", iaddr, 32'hC0);
    hitCycle(32'hC0, 32'h0000_22C0, 1'b0);

    // Request dropped before completion: line 0x84 is still written.
    applyStimulus(1'b0, 1'b1, 32'h84, 1'b0, 1'b1, JUNK);
    applyStimulus(1'b0, 1'b1, 32'h88, 1'b0, 1'b1, JUNK);
    checkOutput("dropAddr", iaddr, 32'h84);
    applyStimulus(1'b0, 1'b0, 32'h88, 1'b0, 1'b0, 32'h0000_3384);
    checkOutput("dropDoneAddr", iaddr, 32'h84);
    hitCycle(32'h84, 32'h0000_3384, 1'b0);

    // Flush on the completing edge: the new line and old lines all miss.
    missFill(32'h100, 32'hAAAA_0100, 1, 1'b1);
    missFill(32'h100, 32'hBBBB_0100, 0, 1'b0);
    hitCycle(32'h100, 32'hBBBB_0100, 1'b0);
    missFill(32'h84, 32'h0000_4484, 0, 1'b0);

    // Flush in IDLE: this cycle still hits on pre-flush state, next misses.
    hitCycle(32'h84, 32'h0000_4484, 1'b1);
    missFill(32'h84, 32'h0000_5584, 0, 1'b0);
    hitCycle(32'h84, 32'h0000_5584, 1'b0);

    // Reset during a fill: no request, no fill, all lines invalid.
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, JUNK);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, JUNK);
    checkOutput("preRstReq", {31'd0, iREN}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0000_6600);
    checkOutput("midRstReq", {31'd0, iREN}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h200, 1'b0, 1'b1, JUNK);
    checkOutput("afterRstReq", {31'd0, iREN}, 32'd0);
    missFill(32'h84, 32'h0000_7784, 0, 1'b0);
    missFill(32'h200, 32'h0000_8800, 1, 1'b0);
    hitCycle(32'h200, 32'h0000_8800, 1'b0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JUNK);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, JUNK);

    while (expCycle.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL missedHit: expected hit in cycle %0d never presented", expCycle[0]);
      void'(expCycle.pop_front());
      void'(expData.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
